// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 convolution window memory: clears the memory pointers, issues
// ROWS*COLS window fetches (stallable by hold), then drains the pipeline and pulses done.
module conv_frame_ctrl #(
    parameter int COLS     = 256,
    parameter int ROWS     = 32,
    parameter int PIPE_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    hold,
    output logic                    mem_clr,
    output logic                    rd_en,
    output logic                    wr_en,
    output logic [$clog2(ROWS)-1:0] row,
    output logic [$clog2(COLS)-1:0] col,
    output logic                    busy,
    output logic                    done
);

    localparam int RW    = $clog2(ROWS);
    localparam int CLW   = $clog2(COLS);
    localparam int CW    = $clog2(ROWS * COLS) + 1;
    localparam int DW    = $clog2(PIPE_LAT) + 1;
    localparam int TOTAL = ROWS * COLS;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         rd_cnt;
    logic [DW-1:0]         drain_cnt;
    logic [PIPE_LAT-1:0]   wr_sr;

    assign rd_en = (state == READ) && !hold;
    assign wr_en = wr_sr[PIPE_LAT-1];

    always_comb begin
        state_next = state;
        mem_clr    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                mem_clr    = 1'b1;
                state_next = READ;
            end
            READ: begin
                if (rd_en && rd_cnt == CW'(TOTAL - 1)) state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == DW'(PIPE_LAT - 1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The write strobe is simply the read strobe delayed by the datapath latency, so every
    // fetch yields exactly one write regardless of stalls or which state we are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            rd_cnt    <= '0;
            drain_cnt <= '0;
            wr_sr     <= '0;
        end else begin
            state <= state_next;
            wr_sr <= (wr_sr << 1) | PIPE_LAT'(rd_en);

            if (state == IDLE && start) begin
                row    <= '0;
                col    <= '0;
                rd_cnt <= '0;
            end else if (rd_en) begin
                rd_cnt <= rd_cnt + CW'(1);
                if (col == CLW'(COLS - 1)) begin
                    col <= '0;
                    row <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CLW'(1);
                end
            end

            if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
            else                drain_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl: a timestamp-based frame model predicts every cycle's
// outputs, a monitor compares them; directed frames also check absolute event cycles and counts.
module tb_conv_frame_ctrl;

    localparam int COLS     = 4;
    localparam int ROWS     = 2;
    localparam int PIPE_LAT = 3;
    localparam int R        = ROWS * COLS;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    hold = 1'b0;
    logic                    mem_clr;
    logic                    rd_en;
    logic                    wr_en;
    logic [$clog2(ROWS)-1:0] row;
    logic [$clog2(COLS)-1:0] col;
    logic                    busy;
    logic                    done;

    conv_frame_ctrl #(.COLS(COLS), .ROWS(ROWS), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .mem_clr(mem_clr), .rd_en(rd_en), .wr_en(wr_en),
        .row(row), .col(col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] ctl;
        int         row;
        int         col;
    } exp_t;

    exp_t exp_q[$];

    // Observed event statistics used by directed tests
    int rd_pulses = 0;
    int wr_pulses = 0;
    int done_pulses = 0;
    int done_cyc = -1;

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    // Reference model: a frame is described by the cycle its start was sampled, how many
    // reads have been made, and when the last read happened; writes come from a due-time queue.
    int frame_t = -1;
    int reads_done = 0;
    int last_rd = -1;
    int wr_due[$];

    always @(negedge clk) begin
        exp_t e;
        bit   act, clr, rdg, rd, dn, wr;
        int   c;
        c   = cyc;
        act = (frame_t >= 0) && (c > frame_t);
        clr = act && (c == frame_t + 1);
        rdg = act && (c > frame_t + 1) && (reads_done < R);
        rd  = rdg && !hold;
        dn  = act && (last_rd >= 0) && (c == last_rd + PIPE_LAT + 1);
        wr  = (wr_due.size() > 0) && (wr_due[0] == c);
        e.ctl = {clr, rd, wr, act, dn};
        e.row = (reads_done % R) / COLS;
        e.col = reads_done % COLS;
        exp_q.push_back(e);

        if (wr) void'(wr_due.pop_front());
        if (rst) begin
            frame_t    = -1;
            reads_done = 0;
            last_rd    = -1;
            wr_due.delete();
        end else begin
            if (rd) begin
                wr_due.push_back(c + PIPE_LAT);
                reads_done++;
                if (reads_done == R) last_rd = c;
            end
            if (dn) frame_t = -1;
            else if (!act && frame_t < 0 && start) begin
                frame_t    = c;
                reads_done = 0;
                last_rd    = -1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("ctl{clr,rd,wr,busy,done}", int'({mem_clr, rd_en, wr_en, busy, done}), int'(e.ctl));
            if (e.ctl[3]) begin
                checkOutput("row", int'(row), e.row);
                checkOutput("col", int'(col), e.col);
            end
        end
        if (rd_en === 1'b1) rd_pulses++;
        if (wr_en === 1'b1) wr_pulses++;
        if (done === 1'b1) begin
            done_pulses++;
            done_cyc = cyc;
        end
    end

    task automatic applyStimulus(input logic s, input logic h, input logic r);
        start = s;
        hold  = h;
        rst   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic clearStats();
        rd_pulses   = 0;
        wr_pulses   = 0;
        done_pulses = 0;
        done_cyc    = -1;
    endtask

    int t;

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("reset_outputs", int'({mem_clr, rd_en, wr_en, busy, done, row, col}), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Basic frame
        clearStats();
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 18; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("basic_done_cycle", done_cyc - t, 13);
        checkOutput("basic_rd_count", rd_pulses, 8);
        checkOutput("basic_wr_count", wr_pulses, 8);

        // Stall during READ
        clearStats();
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) applyStimulus(1'b0, (i == 4 || i == 5), 1'b0);
        checkOutput("stall_done_cycle", done_cyc - t, 15);
        checkOutput("stall_rd_count", rd_pulses, 8);
        checkOutput("stall_wr_count", wr_pulses, 8);

        // Hold in CLEAR and DRAIN has no effect
        clearStats();
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 18; i++) applyStimulus(1'b0, (i == 1 || (i >= 10 && i <= 12)), 1'b0);
        checkOutput("holdcd_done_cycle", done_cyc - t, 13);

        // Start while busy is ignored
        clearStats();
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) applyStimulus((i == 3 || i == 13), 1'b0, 1'b0);
        checkOutput("busy_start_done_cycle", done_cyc - t, 13);
        checkOutput("busy_start_frames", done_pulses, 1);

        // Reset mid-frame, then a fresh frame
        clearStats();
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("midrst_outputs", int'({mem_clr, rd_en, wr_en, busy, done, row, col}), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 10; i < 26; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("midrst_done_cycle", done_cyc - t, 22);
        checkOutput("midrst_rd_count", rd_pulses, 13);
        checkOutput("midrst_wr_count", wr_pulses, 10);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++)
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 149) == 0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_frame_ctrl.md
# conv_frame_ctrl

Frame sequencer for the 3x3-window convolution datapath. It clears the window memory's read and write pointers, then drives the memory read strobe for exactly ROWS×COLS window fetches. It tolerates stalls from downstream and generates the result-write strobe as a latency-matched copy of the read strobe. It sits between the host/top-level start logic and one window-memory + convolution-pipeline instance, and reports busy/done and the coordinate currently being fetched.

## Interface
Parameters:
- COLS, 256, output pixels per row (window positions per padded row)
- ROWS, 32, output rows per frame
- PIPE_LAT, 3, cycles from a read strobe to the matching convolution result at the memory write port (1 memory register + 2 datapath stages); must be ≥1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE
- hold  in  1  downstream stall; suppresses new reads while high
- mem_clr  out  1  one-cycle pulse resetting memory read/write pointers (drives the memory reset via top-level inversion)
- rd_en  out  1  window-fetch strobe to memory rd
- wr_en  out  1  result-write strobe to memory wr
- row  out  $clog2(ROWS)  row of the window fetched when rd_en=1
- col  out  $clog2(COLS)  column of the window fetched when rd_en=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle frame-complete pulse

## Operation
- States: IDLE, CLEAR, READ, DRAIN, DONE; state register, counters, and wr_en are registered.
- IDLE: if start=1, go to CLEAR; else stay.
- CLEAR: mem_clr=1 for exactly one cycle; hold is ignored; go to READ.
- READ:
  - rd_en = (state==READ) & ~hold, combinational from the state register and hold.
  - Each cycle with rd_en=1:
    - col increments.
    - At COLS-1, col wraps to 0 and row increments.
    - A read counter (width $clog2(ROWS*COLS)+1) increments.
  - hold=1 freezes row, col, and the counter.
  - The cycle issuing read number ROWS*COLS-1 (row=ROWS-1, col=COLS-1) with rd_en=1 moves the state to DRAIN.
- DRAIN: rd_en=0 and hold is ignored. A drain counter runs PIPE_LAT cycles, then the state goes to DONE.
- DONE: done=1 for one cycle, then the state goes to IDLE. row/col are cleared to 0 on entry to CLEAR.
- wr_en: output of a PIPE_LAT-deep shift register fed by rd_en, valid in every state. Every read therefore produces exactly one write, PIPE_LAT cycles later, including across stalls.
- start while busy=1: ignored, no queuing.
- Reset (any state, including mid-frame):
  - state ← IDLE.
  - row, col, all counters, and the wr_en shift register ← 0.
  - Outputs in the cycle after reset: mem_clr=0, rd_en=0, wr_en=0, busy=0, done=0, row=0, col=0.
  - No stray write may occur after reset.

## Timing
- start=1 sampled at the end of cycle t: CLEAR in t+1 (mem_clr=1), READ from t+2.
- With no hold:
  - rd_en is high cycles t+2 … t+1+R, where R=ROWS*COLS.
  - wr_en is high cycles t+2+PIPE_LAT … t+1+R+PIPE_LAT.
  - DRAIN spans t+2+R … t+1+R+PIPE_LAT.
  - done is high in t+2+R+PIPE_LAT.
  - IDLE is reached at t+3+R+PIPE_LAT.
- Each hold cycle inside READ extends all later events by one cycle.
- busy is high from t+1 through the done cycle inclusive.
- The last wr_en always occurs in the final DRAIN cycle, one cycle before done.
- A new start may be sampled in the first IDLE cycle after done, giving a minimum frame-to-frame gap of 1 cycle.

## Test plan
- Basic frame (COLS=4, ROWS=2, PIPE_LAT=3), start at cycle 0, no hold -> mem_clr@1; rd_en@2–9 with (row,col) = (0,0)…(0,3),(1,0)…(1,3); wr_en@5–12; done@13; busy@1–13; idle@14.
- Stall: same config, hold=1 in cycles 4–5 -> rd_en@2,3,6–11; (row,col)=(0,2) at cycle 6; wr_en@5,6,9–14; done@15; exactly 8 rd_en and 8 wr_en pulses.
- Hold in CLEAR/DRAIN: hold=1 at cycle 1 and cycles 10–12, no other hold -> timing identical to basic frame.
- start while busy: start pulses at cycles 3 and 13 -> no effect; done@13; single frame; state IDLE at 14.
- Reset mid-frame: rst=1 at cycle 6 -> from cycle 7, all outputs 0, no wr_en for the reads already issued; a new start at cycle 9 yields mem_clr@10 and the full basic-frame sequence shifted by +9.
- Default parameters (256×32, PIPE_LAT=3), start@0 -> 8192 rd_en pulses, 8192 wr_en pulses, last wr_en@8196, done@8197.
